// File: rtl/aes_block_scheduler.sv
// aes_block_scheduler: job-level sequencer for the AES HWPE.
// For each of N 128-bit blocks it issues a source load, an engine run and a
// sink store, stepping both addresses by BLOCK_BYTES per block.
// Optional build macro: AES_WATCHDOG_EN. When defined, every WAIT state is
// bounded by WDOG_CYCLES; on expiry err_o is set and the job ends with done_o.
module aes_block_scheduler #(
  parameter int unsigned CNT_W       = 16,
  parameter int unsigned BLOCK_BYTES = 16,
  parameter int unsigned WDOG_CYCLES = 1024
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             start_i,
  input  logic [31:0]      src_base_i,
  input  logic [31:0]      dst_base_i,
  input  logic [CNT_W-1:0] num_blocks_i,
  output logic             src_req_o,
  output logic [31:0]      src_addr_o,
  input  logic             src_done_i,
  output logic             eng_start_o,
  input  logic             eng_done_i,
  output logic             snk_req_o,
  output logic [31:0]      snk_addr_o,
  input  logic             snk_done_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [CNT_W-1:0] blk_idx_o,
  output logic             err_o
);

  typedef enum logic [3:0] {
    S_IDLE,
    S_LOAD_REQ,
    S_LOAD_WAIT,
    S_ENC_START,
    S_ENC_WAIT,
    S_STORE_REQ,
    S_STORE_WAIT,
    S_NEXT,
    S_DONE
  } state_e;

  state_e           state_q;
  logic [31:0]      src_addr_q;
  logic [31:0]      dst_addr_q;
  logic [CNT_W-1:0] num_q;
  logic [CNT_W-1:0] blk_idx_q;
  logic [CNT_W-1:0] blk_idx_d;
  logic             src_req_q;
  logic             eng_start_q;
  logic             snk_req_q;
  logic             done_q;
  logic             wait_done;
  logic             wait_timeout;

  // Index after the current block; never wraps because num_q caps it.
  assign blk_idx_d = blk_idx_q + CNT_W'(1);

  // Select the responder pulse that belongs to the current WAIT state; stray
  // pulses in any other state are simply not looked at.
  always_comb begin
    wait_done = 1'b0;
    case (state_q)
      S_LOAD_WAIT:  wait_done = src_done_i;
      S_ENC_WAIT:   wait_done = eng_done_i;
      S_STORE_WAIT: wait_done = snk_done_i;
      default:      wait_done = 1'b0;
    endcase
  end

  // Job FSM; the request/start/done pulses are registered alongside the state
  // so each is high exactly during its own state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      src_addr_q  <= '0;
      dst_addr_q  <= '0;
      num_q       <= '0;
      blk_idx_q   <= '0;
      src_req_q   <= 1'b0;
      eng_start_q <= 1'b0;
      snk_req_q   <= 1'b0;
      done_q      <= 1'b0;
    end else if (clear) begin
      state_q     <= S_IDLE;
      src_addr_q  <= '0;
      dst_addr_q  <= '0;
      num_q       <= '0;
      blk_idx_q   <= '0;
      src_req_q   <= 1'b0;
      eng_start_q <= 1'b0;
      snk_req_q   <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      src_req_q   <= 1'b0;
      eng_start_q <= 1'b0;
      snk_req_q   <= 1'b0;
      done_q      <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start_i) begin
            src_addr_q <= src_base_i;
            dst_addr_q <= dst_base_i;
            num_q      <= num_blocks_i;
            blk_idx_q  <= '0;
            if (num_blocks_i == '0) begin
              state_q <= S_DONE;
              done_q  <= 1'b1;
            end else begin
              state_q   <= S_LOAD_REQ;
              src_req_q <= 1'b1;
            end
          end
        end
        S_LOAD_REQ: state_q <= S_LOAD_WAIT;
        S_LOAD_WAIT: begin
          if (wait_done) begin
            state_q     <= S_ENC_START;
            eng_start_q <= 1'b1;
          end else if (wait_timeout) begin
            state_q <= S_DONE;
            done_q  <= 1'b1;
          end
        end
        S_ENC_START: state_q <= S_ENC_WAIT;
        S_ENC_WAIT: begin
          if (wait_done) begin
            state_q   <= S_STORE_REQ;
            snk_req_q <= 1'b1;
          end else if (wait_timeout) begin
            state_q <= S_DONE;
            done_q  <= 1'b1;
          end
        end
        S_STORE_REQ: state_q <= S_STORE_WAIT;
        S_STORE_WAIT: begin
          if (wait_done) begin
            state_q <= S_NEXT;
          end else if (wait_timeout) begin
            state_q <= S_DONE;
            done_q  <= 1'b1;
          end
        end
        S_NEXT: begin
          src_addr_q <= src_addr_q + 32'(BLOCK_BYTES);
          dst_addr_q <= dst_addr_q + 32'(BLOCK_BYTES);
          blk_idx_q  <= blk_idx_d;
          if (blk_idx_d == num_q) begin
            state_q <= S_DONE;
            done_q  <= 1'b1;
          end else begin
            state_q   <= S_LOAD_REQ;
            src_req_q <= 1'b1;
          end
        end
        S_DONE:  state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
    end
  end

`ifdef AES_WATCHDOG_EN
  localparam int unsigned WDOG_W = $clog2(WDOG_CYCLES + 1);

  logic [WDOG_W-1:0] wdog_q;
  logic              in_wait;
  logic              err_q;

  assign in_wait = (state_q == S_LOAD_WAIT) || (state_q == S_ENC_WAIT) ||
                   (state_q == S_STORE_WAIT);
  // The counter reads 0 on the first WAIT cycle, so the limit is hit on the
  // WDOG_CYCLES-th cycle spent waiting.
  assign wait_timeout = in_wait && (wdog_q == WDOG_W'(WDOG_CYCLES - 1));

  // Cycles spent in the current WAIT state; zero everywhere else, which also
  // makes it restart on every WAIT entry.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wdog_q <= '0;
    end else if (clear) begin
      wdog_q <= '0;
    end else if (in_wait) begin
      wdog_q <= wdog_q + 1'b1;
    end else begin
      wdog_q <= '0;
    end
  end

  // Sticky timeout flag, cleared only by an accepted start, clear or reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      err_q <= 1'b0;
    end else if (clear) begin
      err_q <= 1'b0;
    end else if ((state_q == S_IDLE) && start_i) begin
      err_q <= 1'b0;
    end else if (wait_timeout && !wait_done) begin
      err_q <= 1'b1;
    end
  end

  assign err_o = err_q;
`else
  assign wait_timeout = 1'b0;
  assign err_o        = 1'b0;
`endif

  assign src_req_o   = src_req_q;
  assign eng_start_o = eng_start_q;
  assign snk_req_o   = snk_req_q;
  assign done_o      = done_q;
  assign src_addr_o  = src_addr_q;
  assign snk_addr_o  = dst_addr_q;
  assign blk_idx_o   = blk_idx_q;
  assign busy_o      = (state_q != S_IDLE);

endmodule

// File: tb/tb_aes_block_scheduler.sv
// Self-checking bench for aes_block_scheduler. Responders reply after a
// configurable number of cycles; every job is compared against a job-level
// model (address list, block indices, pulse counts, total latency).
// The watchdog scenario runs only when AES_WATCHDOG_EN is defined.
module tb_aes_block_scheduler;
  localparam int CNT_W = 16;
  localparam int WDOG  = 8;

  logic             clk = 1'b0;
  logic             reset, clear, start_i;
  logic [31:0]      src_base_i, dst_base_i;
  logic [CNT_W-1:0] num_blocks_i;
  logic             src_done_i, eng_done_i, snk_done_i;
  logic             src_req_o, eng_start_o, snk_req_o, busy_o, done_o, err_o;
  logic [31:0]      src_addr_o, snk_addr_o;
  logic [CNT_W-1:0] blk_idx_o;

  aes_block_scheduler #(.CNT_W(CNT_W), .BLOCK_BYTES(16), .WDOG_CYCLES(WDOG)) dut (
    .clk(clk), .reset(reset), .clear(clear), .start_i(start_i),
    .src_base_i(src_base_i), .dst_base_i(dst_base_i), .num_blocks_i(num_blocks_i),
    .src_req_o(src_req_o), .src_addr_o(src_addr_o), .src_done_i(src_done_i),
    .eng_start_o(eng_start_o), .eng_done_i(eng_done_i),
    .snk_req_o(snk_req_o), .snk_addr_o(snk_addr_o), .snk_done_i(snk_done_i),
    .busy_o(busy_o), .done_o(done_o), .blk_idx_o(blk_idx_o), .err_o(err_o)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  // Responder delays (cycles from request to done pulse) and countdowns.
  int d_src = 1, d_eng = 1, d_snk = 1;
  int cnt_src = 0, cnt_eng = 0, cnt_snk = 0;
  bit hold_snk = 1'b0;
  bit stray_en = 1'b0;
  bit stray_pend = 1'b0;

  // Observed events of the current job.
  logic [31:0] src_log[$];
  logic [31:0] snk_log[$];
  int          idx_log[$];
  int          sidx_log[$];
  int          eng_cnt, done_cnt, done_cyc, snk_req_cyc, last_eng_idx;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic reset_logs();
    src_log.delete(); snk_log.delete(); idx_log.delete(); sidx_log.delete();
    eng_cnt = 0; done_cnt = 0; done_cyc = -1; snk_req_cyc = -1; last_eng_idx = -1;
  endtask

  // One clock: sample outputs after the edge, log events, drive responders.
  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    if (src_req_o) begin src_log.push_back(src_addr_o); idx_log.push_back(int'(blk_idx_o)); end
    if (eng_start_o) begin eng_cnt++; last_eng_idx = int'(blk_idx_o); end
    if (snk_req_o) begin
      snk_log.push_back(snk_addr_o); sidx_log.push_back(int'(blk_idx_o)); snk_req_cyc = cyc;
    end
    if (done_o) begin done_cnt++; done_cyc = cyc; end

    src_done_i = 1'b0;
    if (cnt_src > 0) begin cnt_src--; src_done_i = (cnt_src == 0); end
    if (src_req_o) cnt_src = d_src;
    eng_done_i = 1'b0;
    if (cnt_eng > 0) begin cnt_eng--; eng_done_i = (cnt_eng == 0); end
    if (eng_start_o) cnt_eng = d_eng;
    snk_done_i = 1'b0;
    if (cnt_snk > 0) begin cnt_snk--; snk_done_i = (cnt_snk == 0); end
    if (snk_req_o && !hold_snk) cnt_snk = d_snk;
    start_i = 1'b0;

    // Stray pulses: src_done alongside its own request, then an eng_done and
    // a competing start during LOAD_WAIT.
    if (stray_en && src_req_o) begin
      src_done_i = 1'b1;
      stray_pend = 1'b1;
    end else if (stray_pend) begin
      eng_done_i   = 1'b1;
      start_i      = 1'b1;
      src_base_i   = 32'h5555_0000;
      num_blocks_i = CNT_W'(9);
      stray_pend   = 1'b0;
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_busy"}, busy_o, 0);
    chk({tag, "_pulses"}, {src_req_o, eng_start_o, snk_req_o, done_o}, 0);
    chk({tag, "_src_addr"}, src_addr_o, 0);
    chk({tag, "_snk_addr"}, snk_addr_o, 0);
    chk({tag, "_blk_idx"}, blk_idx_o, 0);
    chk({tag, "_err"}, err_o, 0);
  endtask

  // Runs a full job and compares it with the job-level model.
  task automatic run_job(input logic [31:0] src, input logic [31:0] dst, input int n);
    int lat, start_cyc;
    logic [31:0] exp_a;
    reset_logs();
    // Start cycle + N blocks of (REQ+START+REQ+NEXT plus the three waits),
    // measured in edges after the start sampling edge.
    lat = 1 + n * (4 + d_src + d_eng + d_snk);
    src_base_i   = src;
    dst_base_i   = dst;
    num_blocks_i = CNT_W'(n);
    start_i      = 1'b1;
    start_cyc    = cyc;
    tick();
    chk("busy_after_start", busy_o, 1);
    while (done_cnt == 0 && (cyc - start_cyc) < lat + 50) tick();
    chk("done_count", done_cnt, 1);
    chk("latency", done_cyc - start_cyc, lat);
    chk("busy_in_done", busy_o, 1);
    chk("src_req_count", src_log.size(), n);
    chk("snk_req_count", snk_log.size(), n);
    chk("eng_start_count", eng_cnt, n);
    for (int b = 0; b < n && b < src_log.size(); b++) begin
      exp_a = src + 32'(b * 16);
      chk("src_addr", src_log[b], exp_a);
      chk("src_blk_idx", idx_log[b], b);
    end
    for (int b = 0; b < n && b < snk_log.size(); b++) begin
      exp_a = dst + 32'(b * 16);
      chk("snk_addr", snk_log[b], exp_a);
      chk("snk_blk_idx", sidx_log[b], b);
    end
    tick();
    chk("busy_after_done", busy_o, 0);
    chk("single_done", done_cnt, 1);
    chk("err_clear", err_o, 0);
    $display("[TB] job src=%08h dst=%08h n=%0d delays=%0d/%0d/%0d latency=%0d",
             src, dst, n, d_src, d_eng, d_snk, done_cyc - start_cyc);
  endtask

  initial begin
    int s;
    reset = 1'b1; clear = 1'b0; start_i = 1'b0;
    src_base_i = '0; dst_base_i = '0; num_blocks_i = '0;
    src_done_i = 1'b0; eng_done_i = 1'b0; snk_done_i = 1'b0;
    reset_logs();
    tick(); tick();
    chk_zero("reset");
    reset = 1'b0;
    tick();
    chk_zero("post_reset");

    // Single block, four blocks, zero blocks with one-cycle responders.
    run_job(32'h1000, 32'h2000, 1);
    run_job(32'h1000, 32'h2000, 4);
    run_job(32'h1000, 32'h2000, 0);

    // Address wrap with stray done/start pulses during the job.
    d_src = 2; stray_en = 1'b1;
    run_job(32'hFFFF_FFF0, 32'h0000_8000, 2);
    stray_en = 1'b0; d_src = 1;

    // Clear in ENC_WAIT of block index 1 of a 3-block job.
    reset_logs();
    d_eng = 4;
    src_base_i = 32'h3000; dst_base_i = 32'h4000; num_blocks_i = CNT_W'(3);
    start_i = 1'b1; s = cyc;
    tick();
    while (eng_cnt < 2 && (cyc - s) < 100) tick();
    chk("clear_eng_idx", last_eng_idx, 1);
    tick();
    clear = 1'b1;
    tick();
    clear = 1'b0;
    chk_zero("clear");
    cnt_src = 0; cnt_eng = 0; cnt_snk = 0;
    src_done_i = 1'b0; eng_done_i = 1'b0; snk_done_i = 1'b0;
    repeat (5) tick();
    chk("clear_no_done", done_cnt, 0);
    chk("clear_idle", busy_o, 0);
    d_eng = 1;
    run_job(32'h3000, 32'h4000, 3);

`ifdef AES_WATCHDOG_EN
    // Withheld sink response: timeout after WDOG cycles in STORE_WAIT.
    reset_logs();
    hold_snk = 1'b1;
    src_base_i = 32'h7000; dst_base_i = 32'h9000; num_blocks_i = CNT_W'(2);
    start_i = 1'b1; s = cyc;
    tick();
    while (done_cnt == 0 && (cyc - s) < 100) tick();
    chk("wdog_done", done_cnt, 1);
    chk("wdog_err", err_o, 1);
    chk("wdog_timing", done_cyc - snk_req_cyc, WDOG + 1);
    chk("wdog_snk_reqs", snk_log.size(), 1);
    tick();
    chk("wdog_err_sticky", err_o, 1);
    chk("wdog_idle", busy_o, 0);
    hold_snk = 1'b0;
    $display("[TB] watchdog job src=7000 dst=9000 n=2 timeout after %0d cycles", WDOG);
    run_job(32'h7000, 32'h9000, 2);
`endif

    // Randomised jobs with random responder delays.
    for (int j = 0; j < 6; j++) begin
      d_src = $urandom_range(1, 3);
      d_eng = $urandom_range(1, 3);
      d_snk = $urandom_range(1, 3);
      run_job($urandom, $urandom, $urandom_range(1, 6));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: observed no finish, expected finish");
    $fatal(1, "timeout");
  end

endmodule
